pixel_write_arb: RTL and testbench

PIXEL_WRITE_ARB -- requirements
Module: pixel_write_arb

---
 rtl/pixel_write_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/pixel_write_arb.sv | 126 ++++++++++++
 tb/tb_pixel_write_arb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_write_arb_pkg.sv
// Shared types and constants for the pixel write arbiter: FSM state encoding,
// RGB field positions inside a packed 24-bit pixel, and default frame geometry.
package pixel_write_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int DEF_WIDTH   = 300;
  localparam int DEF_HEIGHT  = 400;
  localparam int DEF_TIMEOUT = 1024;

  function automatic logic [7:0] rgb_field(input logic [23:0] pix, input int lsb);
    return pix[lsb +: 8];
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin chooser. The pointer names the source with priority; on
// the update strobe it moves to the source that was not just served.
module rr_arb2 (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ptr_q <= 1'b0;
    end else if (upd) begin
      ptr_q <= ~served;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (req[ptr_q]) begin
      gnt[ptr_q] = 1'b1;
    end else if (req[~ptr_q]) begin
      gnt[~ptr_q] = 1'b1;
    end
  end

endmodule

// File: rtl/pixel_write_arb.sv
// Arbitrates two pixel sources onto one frame writer: a whole frame is granted to
// one source, streamed with one-cycle registered latency, then drained on wr_done.
module pixel_write_arb
  import pixel_write_arb_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int HEIGHT  = DEF_HEIGHT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  req,
  input  logic [1:0]  src_valid,
  input  logic [23:0] src0_rgb,
  input  logic [23:0] src1_rgb,
  output logic [1:0]  src_ready,
  input  logic        wr_done,
  output logic        hsync,
  output logic [7:0]  DATA_WRITE_R,
  output logic [7:0]  DATA_WRITE_G,
  output logic [7:0]  DATA_WRITE_B,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err,
  output state_t      state_dbg
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [1:0]        grant_q, arb_gnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [TMR_W-1:0]  timer;
  logic              hsync_q, timeout_q;
  logic [23:0]       pix_q, sel_pix;
  logic              xfer, last_xfer, drain_expire, frame_end;

  // Handshake: a pixel moves on a rising edge where the granted source has
  // src_valid high and src_ready high; ready depends only on state and grant.
  assign src_ready    = (state_q == ST_STREAM) ? grant_q : 2'b00;
  assign xfer         = |(src_valid & src_ready);
  assign last_xfer    = xfer && (pix_cnt == PIX_LAST);
  assign drain_expire = (state_q == ST_DRAIN) && !wr_done && (timer == TMR_LAST);
  assign frame_end    = (state_q == ST_DONE) || drain_expire;
  assign sel_pix      = grant_q[1] ? src1_rgb : src0_rgb;

  rr_arb2 u_arb (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .req     (req),
    .upd     (frame_end),
    .served  (grant_q[1]),
    .gnt     (arb_gnt)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (|req) state_d = ST_STREAM;
      ST_STREAM: if (last_xfer) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (wr_done) state_d = ST_DONE;
        else if (drain_expire) state_d = ST_IDLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_q   <= 2'b00;
      pix_cnt   <= '0;
      timer     <= '0;
      hsync_q   <= 1'b0;
      pix_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      hsync_q   <= xfer;
      timeout_q <= drain_expire;
      if (xfer) pix_q <= sel_pix;
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            grant_q <= arb_gnt;
            pix_cnt <= '0;
          end
        end
        ST_STREAM: begin
          timer <= '0;
          if (xfer && !last_xfer) pix_cnt <= pix_cnt + 1'b1;
        end
        ST_DRAIN: begin
          if (!wr_done && timer != TMR_LAST) timer <= timer + 1'b1;
          if (drain_expire) grant_q <= 2'b00;
        end
        ST_DONE:  grant_q <= 2'b00;
        default:  grant_q <= 2'b00;
      endcase
    end
  end

  assign hsync        = hsync_q;
  assign DATA_WRITE_R = rgb_field(pix_q, R_LSB);
  assign DATA_WRITE_G = rgb_field(pix_q, G_LSB);
  assign DATA_WRITE_B = rgb_field(pix_q, B_LSB);
  assign grant        = grant_q;
  assign busy         = (state_q != ST_IDLE);
  assign frame_done   = (state_q == ST_DONE);
  assign timeout_err  = timeout_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pixel_write_arb.sv
// Frame-level bench for pixel_write_arb: random pixel traffic against a model
// that tracks frame ownership, accepted pixels and drain outcome per frame.
module tb_pixel_write_arb;
  import pixel_write_arb_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int TO = 16;
  localparam int NPIX = W * H;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [1:0]  req;
  logic [1:0]  src_valid;
  logic [23:0] src0_rgb, src1_rgb;
  logic [1:0]  src_ready;
  logic        wr_done;
  logic        hsync;
  logic [7:0]  data_r, data_g, data_b;
  logic [1:0]  grant;
  logic        busy, frame_done, timeout_err;
  state_t      state_dbg;

  int n_checks = 0;
  int n_bad = 0;

  // model state
  logic [23:0] exp_q[$];
  logic [23:0] last_pix;
  bit          ptr_m;
  bit          owner;
  int          accepted;

  pixel_write_arb #(.WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req          (req),
    .src_valid    (src_valid),
    .src0_rgb     (src0_rgb),
    .src1_rgb     (src1_rgb),
    .src_ready    (src_ready),
    .wr_done      (wr_done),
    .hsync        (hsync),
    .DATA_WRITE_R (data_r),
    .DATA_WRITE_G (data_g),
    .DATA_WRITE_B (data_b),
    .grant        (grant),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  function automatic logic [1:0] onehot(input bit s);
    return s ? 2'b10 : 2'b01;
  endfunction

  // driver tasks
  task automatic start_frame(input logic [1:0] r);
    req = r;
    wr_done = 1'($urandom_range(0, 1));
    owner = r[ptr_m] ? ptr_m : !ptr_m;
    cyc();
    check("grant_on_start", {30'd0, grant}, {30'd0, onehot(owner)});
    check("busy_on_start", {31'd0, busy}, 32'd1);
    check("ready_on_start", {30'd0, src_ready}, {30'd0, onehot(owner)});
    check("no_early_hsync", {31'd0, hsync}, 32'd0);
    accepted = 0;
    req = 2'($urandom_range(0, 3));
  endtask

  // mode 0: random valids, 1: both always valid, 2: owner toggles with fixed pattern
  task automatic stream(input int stop_at, input int mode);
    bit xfer;
    for (int c = 0; c < 400 && accepted < stop_at; c++) begin
      check("ready_stream", {30'd0, src_ready}, {30'd0, onehot(owner)});
      src0_rgb = 24'($urandom);
      src1_rgb = 24'($urandom);
      wr_done = 1'($urandom_range(0, 1));
      case (mode)
        1: src_valid = 2'b11;
        2: begin
          src_valid = 2'b11;
          src_valid[owner] = (c % 2 == 0);
          if (owner) src1_rgb = (accepted % 2 == 0) ? 24'h112233 : 24'h445566;
          else       src0_rgb = (accepted % 2 == 0) ? 24'h112233 : 24'h445566;
        end
        default: begin
          src_valid = 2'($urandom_range(0, 3));
          src_valid[owner] = ($urandom_range(0, 3) != 0);
        end
      endcase
      xfer = src_valid[owner];
      if (xfer) begin
        exp_q.push_back(owner ? src1_rgb : src0_rgb);
        accepted++;
      end
      cyc();
      check("hsync", {31'd0, hsync}, {31'd0, xfer});
      if (xfer) last_pix = exp_q.pop_front();
      check("pixel_data", {8'd0, data_r, data_g, data_b}, {8'd0, last_pix});
    end
    check("stream_bound", accepted, stop_at);
  endtask

  task automatic drain(input int k, input bit timeout);
    req = 2'b00;
    src_valid = 2'b11;
    check("ready_drain", {30'd0, src_ready}, 32'd0);
    check("busy_drain", {31'd0, busy}, 32'd1);
    if (timeout) begin
      for (int d = 1; d <= TO; d++) begin
        wr_done = 1'b0;
        cyc();
        check("no_extra_hsync", {31'd0, hsync}, 32'd0);
        check("data_hold", {8'd0, data_r, data_g, data_b}, {8'd0, last_pix});
        check("timeout_err", {31'd0, timeout_err}, {31'd0, (d == TO)});
        check("no_frame_done_to", {31'd0, frame_done}, 32'd0);
        check("busy_to", {31'd0, busy}, {31'd0, (d < TO)});
      end
      check("grant_after_to", {30'd0, grant}, 32'd0);
      cyc();
      check("timeout_one_cycle", {31'd0, timeout_err}, 32'd0);
    end else begin
      for (int d = 0; d <= k; d++) begin
        wr_done = (d == k);
        cyc();
        check("frame_done", {31'd0, frame_done}, {31'd0, (d == k)});
        check("no_timeout", {31'd0, timeout_err}, 32'd0);
        check("busy_drain_wait", {31'd0, busy}, 32'd1);
      end
      wr_done = 1'b0;
      cyc();
      check("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
      check("grant_cleared", {30'd0, grant}, 32'd0);
      check("idle_after_done", {31'd0, busy}, 32'd0);
    end
    src_valid = 2'b00;
    ptr_m = !owner;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, {30'd0, grant}, 32'd0);
    check({tag, "_hsync"}, {31'd0, hsync}, 32'd0);
    check({tag, "_data"}, {8'd0, data_r, data_g, data_b}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {30'd0, src_ready}, 32'd0);
    check({tag, "_fdone"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_terr"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_state"}, {30'd0, state_dbg}, {30'd0, ST_IDLE});
  endtask

  initial begin
    HRESETn = 1'b0;
    req = 2'b00;
    src_valid = 2'b00;
    src0_rgb = '0;
    src1_rgb = '0;
    wr_done = 1'b0;
    ptr_m = 1'b0;
    last_pix = '0;
    repeat (2) cyc();
    check_all_zero("reset");
    HRESETn = 1'b1;
    cyc();
    check_all_zero("post_reset");

    // both sources requesting: 0, 1, 0
    for (int f = 0; f < 3; f++) begin
      start_frame(2'b11);
      check("rr_order", {31'd0, owner}, {31'd0, (f == 1)});
      stream(NPIX, 0);
      drain($urandom_range(0, 6), 1'b0);
    end

    // single source, continuous valid, wr_done a few cycles after the last pixel
    start_frame(2'b01);
    stream(NPIX, 1);
    drain(3, 1'b0);

    // toggling valid with fixed pattern
    start_frame(2'b10);
    stream(NPIX, 2);
    drain(1, 1'b0);

    // writer never finishes
    start_frame(2'b11);
    stream(NPIX, 0);
    drain(0, 1'b1);

    // reset after three pixels, then a full frame from source 0
    start_frame(2'b11);
    stream(3, 1);
    #2;
    HRESETn = 1'b0;
    req = 2'b00;
    src_valid = 2'b00;
    #1;
    check_all_zero("async_reset");
    exp_q.delete();
    last_pix = '0;
    ptr_m = 1'b0;
    cyc();
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_all_zero("after_abort");
    end
    start_frame(2'b11);
    stream(NPIX, 0);
    drain(2, 1'b0);

    // random frames
    for (int f = 0; f < 14; f++) begin
      start_frame(2'($urandom_range(1, 3)));
      stream(NPIX, $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) drain(0, 1'b1);
      else drain($urandom_range(0, 12), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
